// File: rtl/pcm_to_pdm.sv
// Multi-channel PCM-to-PDM modulator: a small frame FIFO feeds a bank of first-order
// sigma-delta modulators that emit one bit per channel on each pdm_clk falling edge.
module pcm_to_pdm #(
  parameter int BIT_WIDTH          = 8,
  parameter int NUM_CHANNELS       = 9,
  parameter int PDM_CLK_DEC_FACTOR = 12,
  parameter int OSR                = 128,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [BIT_WIDTH*NUM_CHANNELS-1:0] pcm_data,
  input  logic                              pcm_valid,
  output logic                              pcm_ready,
  output logic                              pdm_clk,
  output logic [NUM_CHANNELS-1:0]           pdm,
  output logic                              sample_tick,
  output logic                              underrun,
  input  logic                              underrun_clr
);

  localparam int FRAME_W = BIT_WIDTH * NUM_CHANNELS;
  localparam int CNT_W   = (PDM_CLK_DEC_FACTOR > 1) ? $clog2(PDM_CLK_DEC_FACTOR) : 1;
  localparam int STEP_W  = $clog2(OSR);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PDM_CLK_DEC_FACTOR - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(OSR - 1);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]    COUNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]    COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef logic [NUM_CHANNELS-1:0][BIT_WIDTH-1:0] chan_vec_t;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pdm_clk_q, pdm_clk_d;
  logic [STEP_W-1:0]       step_q, step_d;
  chan_vec_t               acc_q, acc_d;
  chan_vec_t               frame_q, frame_d;
  logic [NUM_CHANNELS-1:0] pdm_q, pdm_d;
  logic                    sample_tick_q, sample_tick_d;
  logic                    underrun_q, underrun_d;

  logic [FRAME_W-1:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]          count_q, count_d;

  logic                    wrap_s;
  logic                    step_s;
  logic                    load_s;
  logic                    fifo_empty_s;
  logic                    fifo_full_s;
  logic                    push_s;
  logic                    pop_s;
  logic [BIT_WIDTH:0]      sum_s [NUM_CHANNELS];

  // A step is the cycle where pdm_clk falls; the last step of a window also loads a frame.
  assign wrap_s       = (cnt_q == CNT_LAST);
  assign step_s       = en && wrap_s && pdm_clk_q;
  assign load_s       = step_s && (step_q == STEP_LAST);
  assign fifo_empty_s = (count_q == '0);
  assign fifo_full_s  = (count_q == COUNT_FULL);
  assign push_s       = pcm_valid && !fifo_full_s;
  assign pop_s        = load_s && !fifo_empty_s;

  genvar gk;
  generate
    for (gk = 0; gk < NUM_CHANNELS; gk++) begin : g_sum
      assign sum_s[gk] = {1'b0, acc_q[gk]} + {1'b0, frame_q[gk]};
    end
  endgenerate

  always_comb begin
    cnt_d     = cnt_q;
    pdm_clk_d = pdm_clk_q;
    step_d    = step_q;
    acc_d     = acc_q;
    pdm_d     = pdm_q;
    if (!en) begin
      cnt_d     = '0;
      pdm_clk_d = 1'b0;
      step_d    = '0;
      acc_d     = '0;
      pdm_d     = '0;
    end else begin
      if (wrap_s) begin
        cnt_d     = '0;
        pdm_clk_d = ~pdm_clk_q;
      end else begin
        cnt_d     = cnt_q + CNT_ONE;
      end
      if (step_s) begin
        step_d = load_s ? '0 : step_q + STEP_ONE;
        // The carry out of each accumulator is the PDM bit; the remainder carries on.
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          pdm_d[k] = sum_s[k][BIT_WIDTH];
          acc_d[k] = sum_s[k][BIT_WIDTH-1:0];
        end
      end else begin
        step_d = step_q;
      end
    end
  end

  always_comb begin
    frame_d       = frame_q;
    underrun_d    = underrun_q;
    sample_tick_d = load_s;
    if (pop_s) begin
      frame_d = fifo_mem_q[rd_ptr_q];
    end else begin
      frame_d = frame_q;
    end
    // A new underrun beats a simultaneous clear so the event is never lost.
    if (load_s && fifo_empty_s) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      pdm_clk_q     <= 1'b0;
      step_q        <= '0;
      acc_q         <= '0;
      frame_q       <= '0;
      pdm_q         <= '0;
      sample_tick_q <= 1'b0;
      underrun_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      cnt_q         <= cnt_d;
      pdm_clk_q     <= pdm_clk_d;
      step_q        <= step_d;
      acc_q         <= acc_d;
      frame_q       <= frame_d;
      pdm_q         <= pdm_d;
      sample_tick_q <= sample_tick_d;
      underrun_q    <= underrun_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= pcm_data;
    end
  end

  assign pcm_ready   = !fifo_full_s;
  assign pdm_clk     = pdm_clk_q;
  assign pdm         = pdm_q;
  assign sample_tick = sample_tick_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_pcm_to_pdm.sv
// Self-checking bench for pcm_to_pdm: directed frames with hand-computed bit densities,
// plus sequences for FIFO full, underrun/clear, mid-run reset and enable drop.
module tb_pcm_to_pdm;

  localparam int NCH     = 9;
  localparam int DEC     = 12;
  localparam int WIN_CYC = 3072;
  localparam int HIST_N  = 2048;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [8*NCH-1:0] pcm_data;
  logic             pcm_valid;
  logic             pcm_ready;
  logic             pdm_clk;
  logic [NCH-1:0]   pdm;
  logic             sample_tick;
  logic             underrun;
  logic             underrun_clr;

  pcm_to_pdm #(
    .BIT_WIDTH(8), .NUM_CHANNELS(NCH), .PDM_CLK_DEC_FACTOR(DEC), .OSR(128), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pcm_data(pcm_data), .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready), .pdm_clk(pdm_clk), .pdm(pdm), .sample_tick(sample_tick),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*NCH-1:0]   frame;
    logic [NCH-1:0][7:0] exp;
    int                 win;
  } vec_t;

  vec_t           tbl [6];
  int             checks = 0;
  int             errors = 0;
  int             edge_n = 0;
  bit             track_on = 1'b0;
  int             clk_bad, tick_bad, chg_bad;
  logic [NCH-1:0] prev_pdm;
  logic [NCH-1:0] hist [HIST_N];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic restart_track();
    edge_n   = 0;
    clk_bad  = 0;
    tick_bad = 0;
    chg_bad  = 0;
    prev_pdm = pdm;
    for (int i = 0; i < HIST_N; i++) hist[i] = '0;
    track_on = 1'b1;
  endtask

  // One clk edge; while tracking, pdm_clk/sample_tick are compared to their ideal timing
  // and pdm is captured at every ideal pdm_clk rise (edge 24r+12 holds the bit of step r).
  task automatic tick();
    int r;
    @(posedge clk);
    #1;
    edge_n++;
    if (track_on) begin
      if (pdm_clk !== (((edge_n / DEC) % 2) == 1)) clk_bad++;
      if (sample_tick !== ((edge_n % WIN_CYC) == 0)) tick_bad++;
      if ((pdm !== prev_pdm) && ((edge_n % (2 * DEC)) != 0)) chg_bad++;
      prev_pdm = pdm;
      if ((edge_n % (2 * DEC)) == DEC) begin
        r = (edge_n - DEC) / (2 * DEC);
        if (r < HIST_N) hist[r] = pdm;
      end
    end
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) tick();
  endtask

  function automatic logic [NCH-1:0][7:0] win_ones(input int w);
    logic [NCH-1:0][7:0] c;
    c = '0;
    for (int r = 128 * w + 1; r <= 128 * w + 128; r++) begin
      for (int k = 0; k < NCH; k++) c[k] = c[k] + 8'(hist[r][k]);
    end
    return c;
  endfunction

  initial begin
    int bad;
    int n;
    bit found;
    logic [NCH-1:0] expv;

    // Channels listed ch8 first; expected counts are ones per 128-bit window.
    tbl[0] = '{frame: {9{8'h80}}, exp: {9{8'd64}}, win: 2};
    tbl[1] = '{frame: {8'hC0, 8'hE0, 8'hA0, 8'h60, 8'h20, 8'h01, 8'h40, 8'hFF, 8'h00},
               exp:   {8'd96, 8'd112, 8'd80, 8'd48, 8'd16, 8'd0, 8'd32, 8'd127, 8'd0}, win: 3};
    tbl[2] = '{frame: {8'hC0, 8'hE0, 8'hA0, 8'h60, 8'h20, 8'h01, 8'h40, 8'hFF, 8'h00},
               exp:   {8'd96, 8'd112, 8'd80, 8'd48, 8'd16, 8'd1, 8'd32, 8'd128, 8'd0}, win: 4};
    tbl[3] = '{frame: {8'h08, 8'hF0, 8'hD0, 8'hB0, 8'h90, 8'h70, 8'h50, 8'h30, 8'h10},
               exp:   {8'd4, 8'd120, 8'd104, 8'd88, 8'd72, 8'd56, 8'd40, 8'd24, 8'd8}, win: 5};
    tbl[4] = '{frame: {9{8'h33}}, exp: {9{8'd0}}, win: -1};
    tbl[5] = '{frame: {9{8'h40}}, exp: {9{8'd32}}, win: 8};

    rst = 1'b0; en = 1'b0; pcm_valid = 1'b0; pcm_data = '0; underrun_clr = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pdm_clk", pdm_clk, 1'b0);
    chk("rst_pdm", pdm, 9'h000);
    chk("rst_tick", sample_tick, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_ready", pcm_ready, 1'b1);

    rst = 1'b0; en = 1'b1;
    restart_track();
    run_to(11);   chk("clk_low_e11", pdm_clk, 1'b0);
    run_to(12);   chk("clk_rise_e12", pdm_clk, 1'b1);
    run_to(24);   chk("clk_fall_e24", pdm_clk, 1'b0);
    run_to(3071); chk("no_tick_e3071", sample_tick, 1'b0);
    chk("no_underrun_e3071", underrun, 1'b0);
    run_to(3072); chk("tick_load1", sample_tick, 1'b1);
    chk("underrun_load1", underrun, 1'b1);
    chk("ready_idle", pcm_ready, 1'b1);

    run_to(3100);
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    chk("underrun_cleared", underrun, 1'b0);

    // Frames A..D fill the FIFO; E is offered while full and must be dropped.
    for (int i = 0; i < 4; i++) begin
      pcm_data = tbl[i].frame; pcm_valid = 1'b1; tick();
    end
    chk("ready_low_full", pcm_ready, 1'b0);
    pcm_data = tbl[4].frame;
    repeat (5) tick();
    pcm_valid = 1'b0;
    chk("ready_still_low", pcm_ready, 1'b0);
    run_to(6143); chk("ready_low_pre_pop", pcm_ready, 1'b0);
    run_to(6144); chk("ready_after_pop", pcm_ready, 1'b1);
    chk("tick_load2", sample_tick, 1'b1);
    chk("no_underrun_load2", underrun, 1'b0);
    run_to(18431); chk("no_underrun_load5", underrun, 1'b0);
    run_to(18432); chk("underrun_load6", underrun, 1'b1);

    // Load 7: FIFO empty, clear pulsed and frame F written on the same edge.
    run_to(21503);
    underrun_clr = 1'b1; pcm_valid = 1'b1; pcm_data = tbl[5].frame;
    tick();
    underrun_clr = 1'b0; pcm_valid = 1'b0;
    chk("underrun_set_wins", underrun, 1'b1);
    chk("tick_load7", sample_tick, 1'b1);
    chk("ready_load7", pcm_ready, 1'b1);

    run_to(27660);
    chk("win0_ones", win_ones(0), '0);
    chk("win1_ones", win_ones(1), '0);
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].win >= 0) chk($sformatf("win%0d_ones", tbl[i].win), win_ones(tbl[i].win), tbl[i].exp);
    end
    chk("win6_held", win_ones(6), tbl[3].exp);
    chk("win7_held", win_ones(7), tbl[3].exp);
    bad = 0;
    for (int r = 257; r <= 384; r++) begin
      expv = ((r % 2) == 0) ? 9'h1FF : 9'h000;
      if (hist[r] !== expv) bad++;
    end
    chk("midscale_alternate", bad, 0);
    chk("run1_pdm_clk_timing", clk_bad, 0);
    chk("run1_tick_timing", tick_bad, 0);
    chk("run1_pdm_change_off_step", chg_bad, 0);

    // Asynchronous reset while pdm_clk is high and pdm is driving ones.
    track_on = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 200) begin
      if (pdm_clk === 1'b1 && pdm !== 9'h000) found = 1'b1;
      else begin tick(); n++; end
    end
    chk("midrst_precondition", found, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("midrst_pdm_clk", pdm_clk, 1'b0);
    chk("midrst_pdm", pdm, 9'h000);
    chk("midrst_underrun", underrun, 1'b0);
    chk("midrst_tick", sample_tick, 1'b0);
    chk("midrst_ready", pcm_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b1;
    restart_track();

    // Frame G queued, en dropped for 100 cycles, frame H written while idle.
    pcm_data = {9{8'hC0}}; pcm_valid = 1'b1; tick(); pcm_valid = 1'b0;
    run_to(500);
    chk("pdm_clk_high_before_drop", pdm_clk, 1'b1);
    en = 1'b0; track_on = 1'b0;
    bad = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 50) begin pcm_data = {9{8'h20}}; pcm_valid = 1'b1; end
      tick();
      pcm_valid = 1'b0;
      if (pdm_clk !== 1'b0 || pdm !== 9'h000 || sample_tick !== 1'b0) bad++;
    end
    chk("en_low_idle", bad, 0);
    chk("en_low_ready", pcm_ready, 1'b1);
    en = 1'b1;
    restart_track();
    run_to(9228);
    chk("run2_pdm_clk_timing", clk_bad, 0);
    chk("run2_tick_timing", tick_bad, 0);
    chk("run2_pdm_change_off_step", chg_bad, 0);
    chk("run2_win0_ones", win_ones(0), '0);
    chk("run2_win1_G", win_ones(1), {9{8'd96}});
    chk("run2_win2_H", win_ones(2), {9{8'd16}});
    chk("run2_underrun_load3", underrun, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
